// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART receive/transmit controllers:
// the controller state encoding, default sizing constants and a width helper.
package uart_ctrl_pkg;

  localparam int DEFAULT_NUM_OF_BYTES = 4;
  localparam int DEFAULT_ADDR_WIDTH   = 4;
  localparam int DEFAULT_GAP_TIMEOUT  = 1000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BYTE,
    WRITE,
    DONE,
    ERROR
  } rx_ctrl_state_t;

  // A timeout of 0 (disabled) still needs a one-bit counter to stay legal.
  function automatic int gap_timer_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_rx_gap_timer.sv
// Counts consecutive idle cycles between received bytes and flags the cycle
// in which the configured gap limit is reached.
module uart_rx_gap_timer
  import uart_ctrl_pkg::*;
#(
  parameter int GAP_TIMEOUT = DEFAULT_GAP_TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int          W       = gap_timer_width(GAP_TIMEOUT);
  localparam int          LAST_I  = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LAST   = W'(LAST_I);

  logic [W-1:0] r_count;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en && (r_count != LAST)) begin
      r_count <= r_count + W'(1);
    end
  end

  // Fires during the GAP_TIMEOUT-th counted cycle so the controller leaves at that edge.
  assign expired = (GAP_TIMEOUT != 0) && count_en && !clear && (r_count == LAST);

endmodule

// File: rtl/uart_rx_control.sv
// Receive-side message controller: stores NUM_OF_BYTES UART bytes into RAM at
// consecutive addresses, flagging frame errors and inter-byte gap timeouts.
module uart_rx_control
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_OF_BYTES = DEFAULT_NUM_OF_BYTES,
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int GAP_TIMEOUT  = DEFAULT_GAP_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_enable,
  input  logic                  uart_rx_done,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_frame_err,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [7:0]            mem_write_data,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  reception_done,
  output logic                  rx_error
);

  localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(NUM_OF_BYTES);

  rx_ctrl_state_t          r_state,  w_state_nxt;
  logic [ADDR_WIDTH:0]     r_j,      w_j_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,   w_addr_nxt;
  logic [7:0]              r_data,   w_data_nxt;
  logic                    r_we,     w_we_nxt;
  logic                    r_done,   w_done_nxt;
  logic                    r_err,    w_err_nxt;

  logic                    w_byte_ok;
  logic [ADDR_WIDTH:0]     w_j_inc;
  logic                    w_gap_clear;
  logic                    w_gap_count_en;
  logic                    w_gap_expired;

  assign w_byte_ok = uart_rx_done && !uart_rx_frame_err;
  assign w_j_inc   = r_j + (ADDR_WIDTH + 1)'(1);

  // The gap only matters once a message has started.
  assign w_gap_count_en = (GAP_TIMEOUT != 0) && (r_state == WAIT_BYTE) && (r_j != '0);
  assign w_gap_clear    = (r_state != WAIT_BYTE) || w_byte_ok;

  uart_rx_gap_timer #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_gap_timer (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (w_gap_clear),
    .count_en (w_gap_count_en),
    .expired  (w_gap_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_j     <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_we    <= w_we_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_we_nxt    = 1'b0;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;

    unique case (r_state)
      IDLE: begin
        if (rx_enable) w_state_nxt = WAIT_BYTE;
      end

      WAIT_BYTE: begin
        if (!rx_enable) begin
          w_state_nxt = IDLE;
        end else if (uart_rx_done) begin
          // A byte in the timeout cycle wins over the timeout.
          if (uart_rx_frame_err) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ERROR;
          end else begin
            w_data_nxt  = uart_rx_data;
            w_addr_nxt  = r_j[ADDR_WIDTH-1:0];
            w_we_nxt    = 1'b1;
            w_state_nxt = WRITE;
          end
        end else if (w_gap_expired) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ERROR;
        end
      end

      WRITE: begin
        if (!rx_enable) begin
          w_state_nxt = IDLE;
        end else begin
          w_j_nxt = w_j_inc;
          if (w_j_inc == LAST_COUNT) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = WAIT_BYTE;
          end
        end
      end

      DONE, ERROR: begin
        if (!rx_enable) w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase

    // Entering or sitting in IDLE discards all message progress.
    if (w_state_nxt == IDLE) begin
      w_j_nxt    = '0;
      w_addr_nxt = '0;
      w_data_nxt = '0;
      w_we_nxt   = 1'b0;
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
    end
  end

  assign mem_write_addr   = r_addr;
  assign mem_write_data   = r_data;
  assign mem_write_enable = r_we;
  assign byte_count       = r_j;
  assign reception_done   = r_done;
  assign rx_error         = r_err;

endmodule

// File: tb/tb_uart_rx_control.sv
// Scoreboard bench for uart_rx_control: expected RAM writes are queued as bytes
// are driven and matched against each observed write strobe.
module tb_uart_rx_control;

  localparam int NB = 4;
  localparam int AW = 4;
  localparam int GT = 50;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          rx_enable = 1'b0;
  logic          uart_rx_done = 1'b0;
  logic [7:0]    uart_rx_data = '0;
  logic          uart_rx_frame_err = 1'b0;
  logic [AW-1:0] mem_write_addr;
  logic [7:0]    mem_write_data;
  logic          mem_write_enable;
  logic [AW:0]   byte_count;
  logic          reception_done;
  logic          rx_error;

  uart_rx_control #(
    .NUM_OF_BYTES (NB),
    .ADDR_WIDTH   (AW),
    .GAP_TIMEOUT  (GT)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .rx_enable         (rx_enable),
    .uart_rx_done      (uart_rx_done),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_frame_err (uart_rx_frame_err),
    .mem_write_addr    (mem_write_addr),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .byte_count        (byte_count),
    .reception_done    (reception_done),
    .rx_error          (rx_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            cyc;
  } wr_exp_t;

  wr_exp_t exp_q[$];
  wr_exp_t mon_e;
  int      next_addr = 0;
  int      checks = 0;
  int      failures = 0;
  logic    prev_we = 1'b0;

  logic [7:0] msg_a [NB] = '{8'h48, 8'h65, 8'h6C, 8'h6F};
  logic [7:0] msg_b [NB] = '{8'h31, 8'h32, 8'h33, 8'h34};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_addr"},  32'(mem_write_addr),   32'd0);
    check({tag, "_data"},  32'(mem_write_data),   32'd0);
    check({tag, "_we"},    32'(mem_write_enable), 32'd0);
    check({tag, "_count"}, 32'(byte_count),       32'd0);
    check({tag, "_done"},  32'(reception_done),   32'd0);
    check({tag, "_err"},   32'(rx_error),         32'd0);
  endtask

  // One-cycle uart_rx_done pulse; returns at the negedge where the strobe should show.
  task automatic send_byte(input logic [7:0] d, input logic ferr, input bit expect_wr);
    @(negedge clk);
    uart_rx_done      = 1'b1;
    uart_rx_data      = d;
    uart_rx_frame_err = ferr;
    if (expect_wr) begin
      exp_q.push_back('{addr: AW'(next_addr), data: d, cyc: cyc + 1});
      next_addr++;
    end
    @(negedge clk);
    uart_rx_done      = 1'b0;
    uart_rx_frame_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mem_write_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_write_enable), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr",    32'(mem_write_addr), 32'(mon_e.addr));
        check("wr_data",    32'(mem_write_data), 32'(mon_e.data));
        check("wr_latency", 32'(cyc),            32'(mon_e.cyc));
      end
      if (prev_we) check("strobe_width", 32'(mem_write_enable), 32'd0);
    end
    prev_we = mem_write_enable;
  end

  int  n_quiet;
  bit  got_err;

  initial begin
    // Reset state
    #1 rstn = 1'b0;
    #2 check_idle("reset");
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Normal four-byte message, then an ignored fifth byte in DONE
    rx_enable = 1'b1;
    next_addr = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      send_byte(msg_a[i], 1'b0, 1'b1);
      repeat (18) @(negedge clk);
    end
    check("norm_count", 32'(byte_count),     32'd4);
    check("norm_done",  32'(reception_done), 32'd1);
    check("norm_err",   32'(rx_error),       32'd0);
    check("norm_q",     32'(exp_q.size()),   32'd0);
    send_byte(8'hAA, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("ign_count", 32'(byte_count),     32'd4);
    check("ign_done",  32'(reception_done), 32'd1);
    rx_enable = 1'b0;
    @(negedge clk);
    check_idle("norm_release");

    // Frame error on the second byte
    rx_enable = 1'b1;
    next_addr = 0;
    repeat (2) @(negedge clk);
    send_byte(8'h48, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    send_byte(8'h65, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("ferr_count", 32'(byte_count),     32'd1);
    check("ferr_err",   32'(rx_error),       32'd1);
    check("ferr_done",  32'(reception_done), 32'd0);
    send_byte(8'h6C, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("ferr_hold_count", 32'(byte_count), 32'd1);
    check("ferr_hold_err",   32'(rx_error),   32'd1);
    check("ferr_q",          32'(exp_q.size()), 32'd0);
    rx_enable = 1'b0;
    @(negedge clk);
    check_idle("ferr_release");

    // No timeout before the first byte, then timeout after exactly GT cycles
    rx_enable = 1'b1;
    next_addr = 0;
    repeat (500) @(negedge clk);
    check("pre_first_err",   32'(rx_error),   32'd0);
    check("pre_first_count", 32'(byte_count), 32'd0);
    send_byte(8'h11, 1'b0, 1'b1);
    n_quiet = 0;
    got_err = 1'b0;
    for (int i = 0; i < 200 && !got_err; i++) begin
      @(negedge clk);
      if (rx_error) got_err = 1'b1;
      else n_quiet++;
    end
    check("timeout_seen",   32'(got_err),    32'd1);
    check("timeout_cycles", 32'(n_quiet),    32'(GT));
    check("timeout_count",  32'(byte_count), 32'd1);
    rx_enable = 1'b0;
    @(negedge clk);
    check_idle("timeout_release");

    // Abort: rx_enable drops in the same cycle a byte arrives
    rx_enable = 1'b1;
    next_addr = 0;
    repeat (2) @(negedge clk);
    rx_enable    = 1'b0;
    uart_rx_done = 1'b1;
    uart_rx_data = 8'h5A;
    @(negedge clk);
    uart_rx_done = 1'b0;
    check("abort_we",    32'(mem_write_enable), 32'd0);
    check("abort_count", 32'(byte_count),       32'd0);

    // Async reset mid-message, then a full message from address 0
    rx_enable = 1'b1;
    next_addr = 0;
    repeat (2) @(negedge clk);
    send_byte(8'h21, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    send_byte(8'h22, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    check("mid_count", 32'(byte_count), 32'd2);
    #2 rstn = 1'b0;
    #1 check_idle("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    next_addr = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < NB; i++) begin
      send_byte(msg_b[i], 1'b0, 1'b1);
      repeat (5) @(negedge clk);
    end
    check("restart_count", 32'(byte_count),     32'd4);
    check("restart_done",  32'(reception_done), 32'd1);
    check("restart_q",     32'(exp_q.size()),   32'd0);
    rx_enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
